// File: rtl/pool_window_gen.sv
// 2x2 stride-2 window generator for a max-pooling stage: buffers the even row,
// pairs it with the odd row and presents one registered window per 2x2 block.
module pool_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] n1,
    output logic [DATA_WIDTH-1:0] n2,
    output logic [DATA_WIDTH-1:0] n3,
    output logic [DATA_WIDTH-1:0] n4,
    output logic                  out_valid,
    output logic                  frame_done
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] hold_q;
    logic [DATA_WIDTH-1:0] n1_q, n2_q, n3_q, n4_q;
    logic                  out_valid_q, frame_done_q;
    logic [DATA_WIDTH-1:0] line_q [IMG_WIDTH];

    logic                  accept;
    logic                  win_d;
    logic                  last_d;
    logic [CW-1:0]         col_left;

    assign accept   = in_valid && !reset;
    assign col_left = col_q - CW'(1);

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        win_d  = accept && row_q[0] && col_q[0];
        last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            n1_q         <= '0;
            n2_q         <= '0;
            n3_q         <= '0;
            n4_q         <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= win_d;
            frame_done_q <= win_d && last_d;
            if (accept && row_q[0] && !col_q[0]) begin
                hold_q <= in_data;
            end
            if (win_d) begin
                n1_q <= line_q[col_left];
                n2_q <= line_q[col_q];
                n3_q <= hold_q;
                n4_q <= in_data;
            end
        end
    end

    // Line buffer holds only the even row; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept && !row_q[0]) begin
            line_q[col_q] <= in_data;
        end
    end

    assign n1         = n1_q;
    assign n2         = n2_q;
    assign n3         = n3_q;
    assign n4         = n4_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;

endmodule
